// File: rtl/mul_share_arbiter_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
// MUL_W/MUL_PW describe the DSP multiplier; DEF_LAT is the default result latency.
package mul_share_arbiter_pkg;

  localparam int MUL_W   = 12;
  localparam int MUL_PW  = 24;
  localparam int DEF_LAT = 2;

  // Requester-index width: clog2(n), never narrower than one bit.
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first valid requester at or after ptr.
// Zero latency; grant is all-zero when en is low or nobody is valid.
module mul_rr_picker
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  index
);

  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req_valid[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// One shared W x W multiplier for NREQ requesters, round-robin granted; result LAT edges after handshake.
// Operand side is valid/ready (one grant per cycle); result side has no backpressure.
module mul_share_arbiter
  import mul_share_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = MUL_W,
  parameter int LAT  = DEF_LAT,
  parameter int IDW  = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [2*W-1:0]    res_p,
  output logic              busy,
  output logic [15:0]       op_count
);

  localparam int PW = 2 * W;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] g_idx;
  logic           hs;
  logic [W-1:0]   g_a, g_b;
  logic [W-1:0]   mul_a, mul_b;
  logic [PW-1:0]  mul_p;
  logic           fin_vld;
  logic [IDW-1:0] fin_id;
  logic [PW-1:0]  fin_p;
  logic           pipe_busy;

  mul_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req_valid (req_valid),
    .ptr       (ptr),
    .en        (en),
    .grant     (req_ready),
    .index     (g_idx)
  );

  // req_ready already implies req_valid, so any grant is a handshake.
  assign hs  = |req_ready;
  assign g_a = req_a[g_idx*W +: W];
  assign g_b = req_b[g_idx*W +: W];

  // The single DSP multiplier, full-width so 0xFFF*0xFFF is exact.
  assign mul_p = PW'(mul_a) * PW'(mul_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      op_count <= '0;
    end else if (hs) begin
      ptr <= (g_idx == IDW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
  end

  if (LAT == 1) begin : g_lat1
    // Operands are multiplied straight off the grant mux and registered once.
    assign mul_a = g_a;
    assign mul_b = g_b;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        fin_vld <= 1'b0;
        fin_id  <= '0;
        fin_p   <= '0;
      end else begin
        fin_vld <= hs;
        if (hs) begin
          fin_id <= g_idx;
          fin_p  <= mul_p;
        end
      end
    end

    assign pipe_busy = fin_vld;
  end else begin : g_latn
    logic           s1_vld;
    logic [IDW-1:0] s1_id;
    logic [W-1:0]   s1_a, s1_b;
    logic [LAT-2:0] p_vld;
    logic [IDW-1:0] p_id  [LAT-1];
    logic [PW-1:0]  p_dat [LAT-1];

    assign mul_a = s1_a;
    assign mul_b = s1_b;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_vld <= 1'b0;
        s1_id  <= '0;
        s1_a   <= '0;
        s1_b   <= '0;
        p_vld  <= '0;
        for (int i = 0; i < LAT - 1; i++) begin
          p_id[i]  <= '0;
          p_dat[i] <= '0;
        end
      end else begin
        s1_vld <= hs;
        if (hs) begin
          s1_id <= g_idx;
          s1_a  <= g_a;
          s1_b  <= g_b;
        end
        p_vld[0] <= s1_vld;
        p_id[0]  <= s1_id;
        p_dat[0] <= mul_p;
        for (int i = 1; i < LAT - 1; i++) begin
          p_vld[i] <= p_vld[i-1];
          p_id[i]  <= p_id[i-1];
          p_dat[i] <= p_dat[i-1];
        end
      end
    end

    assign fin_vld   = p_vld[LAT-2];
    assign fin_id    = p_id[LAT-2];
    assign fin_p     = p_dat[LAT-2];
    assign pipe_busy = s1_vld | (|p_vld);
  end

  assign res_valid = fin_vld ? (NREQ'(1) << fin_id) : '0;
  assign res_id    = fin_id;
  assign res_p     = fin_p;
  assign busy      = pipe_busy;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: stimulus pushes expected results, a forked monitor pops and compares.
module tb_mul_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [47:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic [3:0]  res_valid;
  logic [1:0]  res_id;
  logic [23:0] res_p;
  logic        busy;
  logic [15:0] op_count;

  mul_share_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          id;
    logic [23:0] p;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Per-requester operands used whenever several requesters are valid together.
  localparam logic [47:0] A_ALL = {12'h800, 12'h0FF, 12'h010, 12'h001};
  localparam logic [47:0] B_ALL = {12'h800, 12'h101, 12'h020, 12'h002};

  function automatic logic [23:0] rp(input int i);
    case (i)
      0:       return 24'h000002;
      1:       return 24'h000200;
      2:       return 24'h00FFFF;
      default: return 24'h400000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present one cycle of requests; g is the expected grant (-1 for none).
  task automatic issue(input logic [3:0] vld, input logic [47:0] a, input logic [47:0] b,
                       input logic en_v, input int g, input logic [23:0] p, input bit push);
    logic [31:0] e;
    @(posedge clk);
    #1;
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    en        = en_v;
    @(negedge clk);
    e = (g < 0) ? 32'd0 : (32'd1 << g);
    chk("req_ready", req_ready, e);
    if (g >= 0 && push) sb.push_back('{id: g, p: p, cyc: cyc + 2});
  endtask

  task automatic idle();
    issue(4'b0000, 48'h0, 48'h0, 1'b1, -1, 24'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", res_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("res_valid", res_valid, 32'd1 << e.id);
          chk("res_id", res_id, e.id);
          chk("res_p", res_p, e.p);
          chk("res_cycle", cyc, e.cyc);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("res_valid_missing", res_valid, 32'd1 << e.id);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] bz [4];
    reset_n   = 1'b0;
    en        = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    fork
      monitor();
    join_none

    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_id", res_id, 0);
    chk("reset_res_p", res_p, 0);
    chk("reset_busy", busy, 0);
    chk("reset_op_count", op_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single op from requester 1: 0x123 * 0x456 = 0x04EDC2.
    issue(4'b0010, {12'h0, 12'h0, 12'h123, 12'h0}, {12'h0, 12'h0, 12'h456, 12'h0},
          1'b1, 1, 24'h04EDC2, 1'b1);
    bz = '{4'd1, 4'd1, 4'd0, 4'd0};
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("single_busy", busy, bz[k]);
    end
    chk("single_op_count", op_count, 1);

    // Full contention from ptr 0: grants rotate 0,1,2,3,0,1,2,3.
    pulse_reset();
    for (int t = 0; t < 8; t++) issue(4'hF, A_ALL, B_ALL, 1'b1, t % 4, rp(t % 4), 1'b1);
    idle();
    chk("contention_op_count", op_count, 8);
    idle();
    idle();

    // Corner operands.
    issue(4'b0001, {36'h0, 12'hFFF}, {36'h0, 12'hFFF}, 1'b1, 0, 24'hFFE001, 1'b1);
    issue(4'b0100, {12'h0, 12'h000, 24'h0}, {12'h0, 12'hABC, 24'h0}, 1'b1, 2, 24'h000000, 1'b1);
    idle();
    idle();
    idle();

    // ptr held at 3 through the idle cycles: three ops 3,0,1, then en drops.
    issue(4'hF, A_ALL, B_ALL, 1'b1, 3, rp(3), 1'b1);
    issue(4'hF, A_ALL, B_ALL, 1'b1, 0, rp(0), 1'b1);
    issue(4'hF, A_ALL, B_ALL, 1'b1, 1, rp(1), 1'b1);
    bz = '{4'd1, 4'd1, 4'd0, 4'd0};
    for (int k = 0; k < 4; k++) begin
      issue(4'hF, A_ALL, B_ALL, 1'b0, -1, 24'h0, 1'b0);
      chk("en_gated_busy", busy, bz[k]);
    end

    // Two ops in flight (grants 2,3) are discarded by a reset pulse.
    issue(4'hF, A_ALL, B_ALL, 1'b1, 2, 24'h0, 1'b0);
    issue(4'hF, A_ALL, B_ALL, 1'b1, 3, 24'h0, 1'b0);
    pulse_reset();
    issue(4'hF, A_ALL, B_ALL, 1'b1, 0, rp(0), 1'b1);
    idle();
    idle();
    idle();
    chk("after_reset_busy", busy, 0);

    // Sparse requesters 0 and 3 from ptr 1.
    for (int t = 0; t < 4; t++) issue(4'b1001, A_ALL, B_ALL, 1'b1, (t % 2 == 0) ? 3 : 0,
                                      rp((t % 2 == 0) ? 3 : 0), 1'b1);
    idle();
    idle();
    idle();

    // op_count saturation, starting from 0xFFFE.
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    idle();
    chk("sat_preload", op_count, 16'hFFFE);
    issue(4'b1001, A_ALL, B_ALL, 1'b1, 3, rp(3), 1'b1);
    idle();
    chk("sat_reach", op_count, 16'hFFFF);
    issue(4'b1001, A_ALL, B_ALL, 1'b1, 0, rp(0), 1'b1);
    issue(4'b1001, A_ALL, B_ALL, 1'b1, 3, rp(3), 1'b1);
    idle();
    idle();
    idle();
    chk("sat_hold", op_count, 16'hFFFF);
    chk("final_busy", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 12x12 DSP integer multiplier between NREQ requesters, for example the butterfly units of the polynomial multiplier.
- Accepts operand pairs through per-requester valid/ready handshakes and picks one requester per cycle by round-robin.
- Pushes each accepted pair through a fixed-latency pipeline around the multiplier.
- Returns each 24-bit product with a one-hot result strobe identifying the originating requester.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 12, operand width; product width is 2*W
- LAT, 2, cycles from handshake edge to result strobe (1..4)
- IDW, 2, requester-index width, equal to clog2(NREQ)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; pipeline drains regardless
- req_valid  in  NREQ  per-requester operand valid
- req_a  in  NREQ*W  operand A; requester i uses bits [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- req_ready  out  NREQ  one-hot grant; a handshake completes when valid and ready are both high
- res_valid  out  NREQ  one-hot result strobe, one cycle wide
- res_id  out  IDW  index of the requester owning res_p
- res_p  out  2*W  product A*B, unsigned
- busy  out  1  any pipeline stage holds a valid op
- op_count  out  16  count of accepted ops, saturating at 0xFFFF

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - req_ready, res_valid, res_id, res_p, busy and op_count are all 0.
  - Round-robin pointer ptr is 0.
  - All pipeline valid bits are 0.
- Arbitration (combinational):
  - When en=1, the grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready is one-hot on that i, or all-zero if no requester is valid or en=0.
  - req_ready depends on req_valid in the same cycle. Requesters must not make req_valid depend on req_ready.
- Pointer update: on a handshake with requester g, ptr <= (g+1) mod NREQ at the clock edge. With no handshake, ptr holds.
- Throughput: at most one op per cycle, with no bubbles while any requester stays valid.
- Pipeline:
  - Stage 1 registers A, B, id and valid of the granted op.
  - The multiplier is purely combinational A*B at full 2*W width, inferred on the DSP.
  - Stages 2..LAT carry product, id and valid.
  - An op handshaken at edge k produces res_valid[id]=1 during the cycle after edge k+LAT-1, i.e. LAT edges after it was presented. Use LAT=1 if the product must be registered in the same stage as the operands.
- Results: no backpressure. A requester must accept res_valid in the cycle it is asserted. res_id and res_p are only meaningful while res_valid is non-zero; they may hold stale values otherwise.
- Ordering: results emerge in acceptance order.
- Fairness: a continuously valid requester waits at most NREQ-1 cycles for a grant.
- Boundary conditions:
  - en falling while ops are in flight: no new grants; in-flight ops complete and busy falls after the last result.
  - Operands 0 or 0xFFF: the product is exact. 0xFFF*0xFFF = 0xFFE001, with no truncation.
  - op_count: increments on each handshake and stays at 0xFFFF once reached.
  - Reset mid-operation: all in-flight ops are discarded with no result strobe. ptr returns to 0.
  - Requester drops req_valid in the grant cycle: there is no handshake and ptr holds.

Decomposition:
- Shared package holds:
  - constants MUL_W=12 and MUL_PW=24;
  - the requester-index width function (clog2);
  - the default LAT.
- One sub-module, mul_rr_picker: combinational round-robin one-hot picker with inputs req_valid, ptr and en, and outputs grant and index.
- The multiplier itself is the existing DSP integer multiplier, instantiated once.
- Pipeline registers and counters live in the top level.

Test Plan:
- Single op: reset, then requester 1 presents A=0x123, B=0x456 for one cycle -> req_ready=0010 that cycle; after LAT=2 edges, res_valid=0010, res_id=1, res_p=0x04EDC2 for exactly one cycle; busy then returns to 0.
- Full contention: all 4 valid continuously for 8 cycles with ptr=0 -> grants 0,1,2,3,0,1,2,3; results return in that order, each exact; op_count=8.
- Corners: A=0xFFF, B=0xFFF -> res_p=0xFFE001; A=0, B=0xABC -> res_p=0.
- en gating: 3 ops in flight, en driven low -> req_ready stays 0; all 3 results still appear on consecutive cycles; busy deasserts the cycle after the last one.
- Mid-op reset: pulse reset_n low for 1 cycle while 2 ops are in flight -> no res_valid afterwards; op_count=0; next grant with all requesters valid goes to requester 0.
- Sparse fairness: requesters 0 and 3 valid only, continuously -> grants alternate 0,3,0,3; op_count saturates correctly when forced from 0xFFFE through 3 more ops (ends at 0xFFFF).
